// File: rtl/lru_victim_select.sv
// LRU victim selector: per-way saturating age stamps feed a pipelined binary
// comparator tree; invalid ways beat valid ones, oldest stamp wins, locked ways never chosen.
module lru_victim_select #(
  parameter int WAYS       = 16,
  parameter int STAMP_W    = 16,
  parameter int PIPE_EVERY = 2,
  parameter int IDX_W      = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [IDX_W-1:0] access_i,
  input  logic [WAYS-1:0]  valid_mask_i,
  input  logic [WAYS-1:0]  lock_mask_i,
  output logic [IDX_W-1:0] victim_o,
  output logic             victim_none_o,
  output logic             victim_ready_o
);

  localparam int LVLS   = $clog2(WAYS);
  localparam int LAT    = 1 + (LVLS + PIPE_EVERY - 1) / PIPE_EVERY;
  localparam int KEY_W  = STAMP_W + 1;
  localparam int BUSY_W = $clog2(LAT + 1);

  logic [WAYS-1:0][STAMP_W-1:0] stamp_q, stamp_d;
  logic [WAYS-1:0]              valid_q, lock_q;

  always_comb begin
    stamp_d = stamp_q;
    if (en_i) begin
      for (int i = 0; i < WAYS; i++) begin
        if (access_i == IDX_W'(i)) begin
          stamp_d[i] = '0;
        end else if (stamp_q[i] != {STAMP_W{1'b1}}) begin
          stamp_d[i] = stamp_q[i] + STAMP_W'(1);
        end
      end
    end
  end

  // Mask copies clear on reset so the first post-reset cycle counts as a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_q <= '0;
      valid_q <= '0;
      lock_q  <= '0;
    end else begin
      stamp_q <= stamp_d;
      valid_q <= valid_mask_i;
      lock_q  <= lock_mask_i;
    end
  end

  for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
    localparam int N   = WAYS >> l;
    localparam bit REG = ((l % PIPE_EVERY) == 0) && (l != LVLS);

    logic [2*N-1:0]            in_cand;
    logic [2*N-1:0][KEY_W-1:0] in_key;
    logic [2*N-1:0][IDX_W-1:0] in_idx;
    logic [N-1:0]              r_win, cand_c, cand;
    logic [N-1:0][IDX_W-1:0]   idx_c, idx;

    if (l == 1) begin : g_leaf
      assign in_cand = ~lock_q;
      for (genvar i = 0; i < WAYS; i++) begin : g_way
        assign in_key[i] = {~valid_q[i], stamp_q[i]};
        assign in_idx[i] = IDX_W'(i);
      end
    end else begin : g_up
      assign in_cand = g_lvl[l-1].cand;
      assign in_key  = g_lvl[l-1].g_key.key;
      assign in_idx  = g_lvl[l-1].idx;
    end

    // Right child only wins on a strictly larger key, so ties keep the lower index.
    for (genvar i = 0; i < N; i++) begin : g_node
      assign r_win[i]  = in_cand[2*i+1] && (!in_cand[2*i] || (in_key[2*i+1] > in_key[2*i]));
      assign cand_c[i] = in_cand[2*i] | in_cand[2*i+1];
      assign idx_c[i]  = r_win[i] ? in_idx[2*i+1] : in_idx[2*i];
    end

    if (l < LVLS) begin : g_key
      logic [N-1:0][KEY_W-1:0] key_c, key;
      for (genvar i = 0; i < N; i++) begin : g_kn
        assign key_c[i] = r_win[i] ? in_key[2*i+1] : in_key[2*i];
      end
      if (REG) begin : g_kreg
        always_ff @(posedge clk) begin
          if (reset) key <= '0;
          else       key <= key_c;
        end
      end else begin : g_kwire
        assign key = key_c;
      end
    end

    if (REG) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          cand <= '0;
          idx  <= '0;
        end else begin
          cand <= cand_c;
          idx  <= idx_c;
        end
      end
    end else begin : g_wire
      assign cand = cand_c;
      assign idx  = idx_c;
    end
  end

  logic             root_cand;
  logic [IDX_W-1:0] root_idx;
  logic [IDX_W-1:0] victim_q, victim_d;
  logic             none_q, none_d;

  assign root_cand = g_lvl[LVLS].cand[0];
  assign root_idx  = g_lvl[LVLS].idx[0];
  assign victim_d  = root_cand ? root_idx : '0;
  assign none_d    = ~root_cand;

  logic              load_c;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic              ready_q, ready_d;

  assign load_c = en_i | (valid_mask_i != valid_q) | (lock_mask_i != lock_q);

  always_comb begin
    busy_d = busy_q;
    if (load_c) begin
      busy_d = BUSY_W'(LAT);
    end else if (busy_q != '0) begin
      busy_d = busy_q - BUSY_W'(1);
    end
  end

  assign ready_d = (busy_d == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      victim_q <= '0;
      none_q   <= 1'b0;
      busy_q   <= BUSY_W'(LAT);
      ready_q  <= 1'b0;
    end else begin
      victim_q <= victim_d;
      none_q   <= none_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign victim_o       = victim_q;
  assign victim_none_o  = none_q;
  assign victim_ready_o = ready_q;

endmodule

// File: tb/tb_lru_victim_select.sv
// Directed checks on the default and a narrow-stamp instance, plus randomized
// runs on several WAYS/PIPE_EVERY combinations against an age-list reference model.
module tb_lru_victim_select;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int sweep_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Default-parameter instance
  logic        d_reset, d_en, d_none, d_rdy;
  logic [3:0]  d_acc, d_vic;
  logic [15:0] d_valid, d_lock;

  lru_victim_select u_dflt (
    .clk(clk), .reset(d_reset), .en_i(d_en), .access_i(d_acc),
    .valid_mask_i(d_valid), .lock_mask_i(d_lock),
    .victim_o(d_vic), .victim_none_o(d_none), .victim_ready_o(d_rdy)
  );

  // Narrow-stamp instance for saturation
  logic        s_reset, s_en, s_none, s_rdy;
  logic [3:0]  s_acc, s_vic;
  logic [15:0] s_valid, s_lock;

  lru_victim_select #(.WAYS(16), .STAMP_W(4), .PIPE_EVERY(2)) u_sat (
    .clk(clk), .reset(s_reset), .en_i(s_en), .access_i(s_acc),
    .valid_mask_i(s_valid), .lock_mask_i(s_lock),
    .victim_o(s_vic), .victim_none_o(s_none), .victim_ready_o(s_rdy)
  );

  initial begin
    d_reset = 1'b1; d_en = 1'b0; d_acc = '0; d_valid = 16'hFFFF; d_lock = '0;
    s_reset = 1'b1; s_en = 1'b0; s_acc = '0; s_valid = 16'hFFFF; s_lock = '0;
    wait_cyc(2);
    check("rst victim", 32'(d_vic), 32'd0);
    check("rst none", 32'(d_none), 32'd0);
    check("rst ready", 32'(d_rdy), 32'd0);
    d_reset = 1'b0; s_reset = 1'b0;
    wait_cyc(3);
    check("ready early", 32'(d_rdy), 32'd0);
    wait_cyc(1);
    check("ready after rst", 32'(d_rdy), 32'd1);
    check("victim after rst", 32'(d_vic), 32'd0);
    check("none after rst", 32'(d_none), 32'd0);

    for (int i = 0; i < 16; i++) begin
      d_en = 1'b1; d_acc = 4'(i);
      wait_cyc(1);
      check("burst ready low", 32'(d_rdy), 32'd0);
    end
    d_en = 1'b0;
    wait_cyc(1);
    check("burst victim lag", 32'(d_vic), 32'd15);
    wait_cyc(1);
    check("burst victim", 32'(d_vic), 32'd0);
    check("burst ready still low", 32'(d_rdy), 32'd0);
    wait_cyc(1);
    check("burst ready", 32'(d_rdy), 32'd1);

    d_valid = 16'hFFFF & ~16'h1200;
    wait_cyc(4);
    check("invalid pref ready", 32'(d_rdy), 32'd1);
    check("invalid pref", 32'(d_vic), 32'd9);
    d_lock = 16'h0200;
    wait_cyc(4);
    check("invalid lock9", 32'(d_vic), 32'd12);
    d_lock = 16'h1200;
    wait_cyc(4);
    check("invalid lock9_12", 32'(d_vic), 32'd0);
    check("invalid lock none", 32'(d_none), 32'd0);

    d_lock = 16'hFFFF;
    wait_cyc(4);
    check("all locked none", 32'(d_none), 32'd1);
    check("all locked victim", 32'(d_vic), 32'd0);
    d_lock = 16'hFF7F;
    wait_cyc(2);
    check("unlock7 lag", 32'(d_none), 32'd1);
    wait_cyc(1);
    check("unlock7 none", 32'(d_none), 32'd0);
    check("unlock7 victim", 32'(d_vic), 32'd7);
    wait_cyc(1);
    check("unlock7 ready", 32'(d_rdy), 32'd1);

    d_lock = '0; d_valid = 16'hFFFF; d_en = 1'b1; d_acc = 4'd0;
    wait_cyc(1);
    d_en = 1'b0;
    check("en+mask ready low", 32'(d_rdy), 32'd0);
    wait_cyc(2);
    check("en+mask victim", 32'(d_vic), 32'd1);
    wait_cyc(1);
    check("en+mask ready", 32'(d_rdy), 32'd1);

    for (int i = 0; i < 20; i++) begin
      s_en = 1'b1; s_acc = 4'd3;
      wait_cyc(1);
    end
    s_en = 1'b0;
    wait_cyc(4);
    check("sat ready", 32'(s_rdy), 32'd1);
    check("sat victim", 32'(s_vic), 32'd0);
    check("sat none", 32'(s_none), 32'd0);
    s_en = 1'b1; s_acc = 4'd0;
    wait_cyc(1);
    s_en = 1'b0;
    wait_cyc(4);
    check("sat victim after 0", 32'(s_vic), 32'd1);

    for (int k = 0; k < 3000 && sweep_done < 9; k++) @(negedge clk);
    check("sweeps finished", 32'(sweep_done), 32'd9);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  for (genvar g = 0; g < 9; g++) begin : g_sw
    localparam int W     = (g < 3) ? 2 : ((g < 6) ? 8 : 32);
    localparam int PE    = (g % 3) + 1;
    localparam int SW    = 3;
    localparam int LV    = $clog2(W);
    localparam int LAT_G = 1 + (LV + PE - 1) / PE;
    localparam int SMAX  = (1 << SW) - 1;

    logic          r, e, vn, vr;
    logic [LV-1:0] acc, vic;
    logic [W-1:0]  vm, lm;

    lru_victim_select #(.WAYS(W), .STAMP_W(SW), .PIPE_EVERY(PE)) u_dut (
      .clk(clk), .reset(r), .en_i(e), .access_i(acc),
      .valid_mask_i(vm), .lock_mask_i(lm),
      .victim_o(vic), .victim_none_o(vn), .victim_ready_o(vr)
    );

    initial begin
      int age [W];
      logic [W-1:0] vm_r, lm_r;
      int cyc, last_evt, quiet, best;
      bit was_rst, exp_rdy;

      r = 1'b1; e = 1'b0; acc = '0; vm = '1; lm = '0;
      for (int i = 0; i < W; i++) age[i] = 0;
      vm_r = '0; lm_r = '0;
      cyc = 0; last_evt = 0; quiet = 0; was_rst = 1'b1;

      for (int step = 0; step < 800; step++) begin
        @(negedge clk);
        // Reference pick: unlocked only; invalid before valid; then oldest; then lowest index.
        best = -1;
        for (int i = 0; i < W; i++) begin
          if (!lm_r[i]) begin
            if (best < 0) best = i;
            else if ((!vm_r[i] && vm_r[best]) || (vm_r[i] == vm_r[best] && age[i] > age[best])) best = i;
          end
        end
        exp_rdy = ((cyc - last_evt) >= LAT_G);
        if (was_rst) begin
          check("sweep rst victim", 32'(vic), 32'd0);
          check("sweep rst none", 32'(vn), 32'd0);
          check("sweep rst ready", 32'(vr), 32'd0);
        end else begin
          check("sweep ready", 32'(vr), 32'(exp_rdy));
          if (exp_rdy) begin
            check("sweep victim", 32'(vic), (best < 0) ? 32'd0 : 32'(best));
            check("sweep none", 32'(vn), (best < 0) ? 32'd1 : 32'd0);
          end
        end

        r = (step == 400) || (step > 10 && $urandom_range(0, 79) == 0);
        if (quiet > 0) begin
          quiet--;
          e = 1'b0;
        end else begin
          e = ($urandom_range(0, 2) != 0);
          acc = LV'($urandom_range(0, W - 1));
          if ($urandom_range(0, 7) == 0)
            vm = ($urandom_range(0, 1) == 1) ? '1 : (W'($urandom) | W'($urandom));
          if ($urandom_range(0, 7) == 0)
            lm = ($urandom_range(0, 3) == 0) ? '0 : (W'($urandom) & W'($urandom));
          if ($urandom_range(0, 5) == 0) quiet = $urandom_range(LAT_G, LAT_G + 5);
        end

        cyc++;
        if (r) begin
          for (int i = 0; i < W; i++) age[i] = 0;
          vm_r = '0; lm_r = '0;
          last_evt = cyc;
          was_rst = 1'b1;
        end else begin
          was_rst = 1'b0;
          if (e || vm != vm_r || lm != lm_r) last_evt = cyc;
          if (e) begin
            for (int i = 0; i < W; i++) begin
              if (i == int'(acc)) age[i] = 0;
              else if (age[i] < SMAX) age[i]++;
            end
          end
          vm_r = vm; lm_r = lm;
        end
      end
      r = 1'b0; e = 1'b0;
      sweep_done++;
    end
  end

endmodule
